// File: rtl/packet_slot_buffer.sv
// packet_slot_buffer
//   Multi-slot packet FIFO between the MAC datapath (writer) and the host
//   DMA/CSR engine (reader). Each slot holds one packet of up to slot_bytes_p
//   bytes. The writer fills the tail slot by byte address and then commits or
//   aborts it. The reader sees the head slot's size and reads it by word
//   address. It then frees the slot.
//
//   Optional feature: define PACKET_SLOT_BUFFER_STATS_EN to add the saturating
//   commit/abort counters stat_commit_o / stat_abort_o.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   read_slot_v_o             head slot holds a committed packet
//   read_slot_ready_and_i     release head slot
//   read_size_r_o             size (bytes) of head packet
//   read_v_i/read_addr_i      word read of head slot (byte address)
//   read_data_v_o/read_data_o read word, valid one cycle after the read
//   write_slot_v_i            commit tail slot
//   write_slot_ready_and_o    a free tail slot exists
//   write_slot_abort_i        discard tail slot contents (size -> 0)
//   write_size_v_i/_size_i    latch packet size for tail slot
//   write_v_i/addr/data/op    byte-masked write, 1<<op bytes, lane-aligned data
//   slot_count_o              number of committed slots
//   err_misalign_o            sticky: misaligned or oversize-op access
//   err_oversize_o            sticky: commit with size > slot_bytes_p

// One byte lane of the packet memory: plain synchronous-write,
// registered-read RAM so it maps onto block RAM.
module packet_slot_buffer_lane #(
  parameter int depth_p = 2,
  parameter int idx_w_p = 1
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [idx_w_p-1:0] waddr_i,
  input  logic [7:0]         wdata_i,
  input  logic               re_i,
  input  logic [idx_w_p-1:0] raddr_i,
  output logic [7:0]         rdata_o
);
  logic [7:0] mem_q [depth_p];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module packet_slot_buffer #(
  parameter int slot_p       = 4,
  parameter int slot_bytes_p = 2048,
  parameter int data_width_p = 64,
  parameter int size_width_p = 16,
  localparam int addr_w_lp   = $clog2(slot_bytes_p),
  localparam int count_w_lp  = $clog2(slot_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  output logic                    read_slot_v_o,
  input  logic                    read_slot_ready_and_i,
  output logic [size_width_p-1:0] read_size_r_o,
  input  logic                    read_v_i,
  input  logic [addr_w_lp-1:0]    read_addr_i,
  output logic                    read_data_v_o,
  output logic [data_width_p-1:0] read_data_o,
  input  logic                    write_slot_v_i,
  output logic                    write_slot_ready_and_o,
  input  logic                    write_slot_abort_i,
  input  logic                    write_size_v_i,
  input  logic [size_width_p-1:0] write_size_i,
  input  logic                    write_v_i,
  input  logic [addr_w_lp-1:0]    write_addr_i,
  input  logic [data_width_p-1:0] write_data_i,
  input  logic [2:0]              write_op_size_i,
  output logic [count_w_lp-1:0]   slot_count_o,
  output logic                    err_misalign_o,
  output logic                    err_oversize_o
`ifdef PACKET_SLOT_BUFFER_STATS_EN
  ,
  output logic [15:0]             stat_commit_o,
  output logic [15:0]             stat_abort_o
`endif
);
  localparam int bytes_lp    = data_width_p / 8;
  localparam int lg_bytes_lp = $clog2(bytes_lp);
  localparam int words_lp    = slot_bytes_p / bytes_lp;
  localparam int depth_lp    = slot_p * words_lp;
  localparam int idx_w_lp    = (depth_lp > 1) ? $clog2(depth_lp) : 1;
  localparam int ptr_w_lp    = (slot_p > 1) ? $clog2(slot_p) : 1;

  // ---------------- state ----------------
  logic [ptr_w_lp-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [count_w_lp-1:0]   count_q, count_d;
  logic [size_width_p-1:0] size_q [slot_p];
  logic [size_width_p-1:0] size_d [slot_p];
  logic                    rvld_q, rvld_d;
  logic                    err_mis_q, err_mis_d;
  logic                    err_over_q, err_over_d;

  // ---------------- handshakes ----------------
  // All slot-level handshakes come from the registered count only.
  logic wr_rdy, rd_v, deq, abort, commit, size_set;

  assign wr_rdy   = (count_q != count_w_lp'(slot_p));
  assign rd_v     = (count_q != '0);
  assign deq      = rd_v & read_slot_ready_and_i;
  assign abort    = write_slot_abort_i & wr_rdy;
  assign commit   = write_slot_v_i & wr_rdy & ~write_slot_abort_i;
  assign size_set = write_size_v_i & wr_rdy;

  // Size committed this cycle: a same-cycle size latch takes effect first.
  logic [size_width_p-1:0] wsize_eff;
  logic                    oversize;

  assign wsize_eff = size_set ? write_size_i : size_q[wptr_q];
  assign oversize  = 64'(wsize_eff) > 64'(slot_bytes_p);

  // ---------------- write decode ----------------
  logic [31:0]               op_bytes, w_off;
  logic                      w_mis, w_en;
  logic [bytes_lp-1:0]       be;
  logic [idx_w_lp-1:0]       widx;

  assign op_bytes = 32'd1 << write_op_size_i;
  assign w_off    = 32'(write_addr_i[lg_bytes_lp-1:0]);
  // Misaligned to its own size, or wider than one memory word.
  assign w_mis    = ((32'(write_addr_i) & (op_bytes - 32'd1)) != 32'd0) ||
                    (op_bytes > 32'(bytes_lp));
  assign w_en     = write_v_i & wr_rdy & ~w_mis;
  assign widx     = idx_w_lp'(32'(wptr_q) * 32'(words_lp) +
                              32'(write_addr_i >> lg_bytes_lp));

  always_comb begin
    be = '0;
    for (int i = 0; i < bytes_lp; i++)
      be[i] = w_en && (32'(i) >= w_off) && (32'(i) < w_off + op_bytes);
  end

  // ---------------- read decode ----------------
  // The slot is folded into the registered RAM address, so a read issued in
  // the same cycle as its slot is freed still returns that slot's data.
  logic                      r_en, r_mis;
  logic [idx_w_lp-1:0]       ridx;
  logic [bytes_lp-1:0][7:0]  rdata;

  assign r_en  = read_v_i & rd_v;
  assign r_mis = (read_addr_i[lg_bytes_lp-1:0] != '0);
  assign ridx  = idx_w_lp'(32'(rptr_q) * 32'(words_lp) +
                           32'(read_addr_i >> lg_bytes_lp));

  // ---------------- memory lanes ----------------
  for (genvar g = 0; g < bytes_lp; g++) begin : g_lane
    packet_slot_buffer_lane #(
      .depth_p (depth_lp),
      .idx_w_p (idx_w_lp)
    ) u_lane (
      .clk_i   (clk_i),
      .we_i    (be[g]),
      .waddr_i (widx),
      .wdata_i (write_data_i[8*g +: 8]),
      .re_i    (r_en),
      .raddr_i (ridx),
      .rdata_o (rdata[g])
    );
  end

  // ---------------- next state ----------------
  always_comb begin
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    size_d     = size_q;
    rvld_d     = r_en;
    err_mis_d  = err_mis_q;
    err_over_d = err_over_q;

    // Order matters: size latch, then abort clear, then commit clamp.
    if (size_set) size_d[wptr_q] = write_size_i;
    if (abort)    size_d[wptr_q] = '0;
    if (commit) begin
      size_d[wptr_q] = oversize ? size_width_p'(slot_bytes_p) : wsize_eff;
      if (oversize) err_over_d = 1'b1;
      wptr_d = (wptr_q == ptr_w_lp'(slot_p - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (deq)
      rptr_d = (rptr_q == ptr_w_lp'(slot_p - 1)) ? '0 : rptr_q + 1'b1;

    case ({commit, deq})
      2'b10:   count_d = count_q + count_w_lp'(1);
      2'b01:   count_d = count_q - count_w_lp'(1);
      default: count_d = count_q;
    endcase

    if ((write_v_i & wr_rdy & w_mis) | (r_en & r_mis)) err_mis_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      size_q     <= '{default: '0};
      rvld_q     <= 1'b0;
      err_mis_q  <= 1'b0;
      err_over_q <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      size_q     <= size_d;
      rvld_q     <= rvld_d;
      err_mis_q  <= err_mis_d;
      err_over_q <= err_over_d;
    end
  end

  // ---------------- optional statistics ----------------
`ifdef PACKET_SLOT_BUFFER_STATS_EN
  logic [15:0] stat_commit_q, stat_commit_d;
  logic [15:0] stat_abort_q, stat_abort_d;

  always_comb begin
    stat_commit_d = stat_commit_q;
    stat_abort_d  = stat_abort_q;
    if (commit && (stat_commit_q != '1)) stat_commit_d = stat_commit_q + 16'd1;
    if (abort  && (stat_abort_q  != '1)) stat_abort_d  = stat_abort_q  + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_commit_q <= '0;
      stat_abort_q  <= '0;
    end else begin
      stat_commit_q <= stat_commit_d;
      stat_abort_q  <= stat_abort_d;
    end
  end

  assign stat_commit_o = stat_commit_q;
  assign stat_abort_o  = stat_abort_q;
`endif

  // ---------------- outputs ----------------
  assign read_slot_v_o          = rd_v;
  assign write_slot_ready_and_o = wr_rdy;
  assign read_size_r_o          = size_q[rptr_q];
  assign read_data_v_o          = rvld_q;
  assign read_data_o            = rdata;
  assign slot_count_o           = count_q;
  assign err_misalign_o         = err_mis_q;
  assign err_oversize_o         = err_over_q;
endmodule

// File: tb/tb_packet_slot_buffer.sv
// Directed bench for packet_slot_buffer (slot_p=4, 2048 B slots, 64-bit data).
// A vector table drives one cycle per entry and checks the registered outputs
// just after the clock edge; hand sequences cover reset and misaligned reads.
module tb_packet_slot_buffer;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        read_slot_v_o, read_slot_ready_and_i;
  logic [15:0] read_size_r_o;
  logic        read_v_i;
  logic [10:0] read_addr_i;
  logic        read_data_v_o;
  logic [63:0] read_data_o;
  logic        write_slot_v_i, write_slot_ready_and_o, write_slot_abort_i;
  logic        write_size_v_i;
  logic [15:0] write_size_i;
  logic        write_v_i;
  logic [10:0] write_addr_i;
  logic [63:0] write_data_i;
  logic [2:0]  write_op_size_i;
  logic [2:0]  slot_count_o;
  logic        err_misalign_o, err_oversize_o;
`ifdef PACKET_SLOT_BUFFER_STATS_EN
  logic [15:0] stat_commit_o, stat_abort_o;
`endif

  packet_slot_buffer #(
    .slot_p(4), .slot_bytes_p(2048), .data_width_p(64), .size_width_p(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .read_slot_v_o(read_slot_v_o), .read_slot_ready_and_i(read_slot_ready_and_i),
    .read_size_r_o(read_size_r_o), .read_v_i(read_v_i), .read_addr_i(read_addr_i),
    .read_data_v_o(read_data_v_o), .read_data_o(read_data_o),
    .write_slot_v_i(write_slot_v_i), .write_slot_ready_and_o(write_slot_ready_and_o),
    .write_slot_abort_i(write_slot_abort_i), .write_size_v_i(write_size_v_i),
    .write_size_i(write_size_i), .write_v_i(write_v_i), .write_addr_i(write_addr_i),
    .write_data_i(write_data_i), .write_op_size_i(write_op_size_i),
    .slot_count_o(slot_count_o), .err_misalign_o(err_misalign_o),
    .err_oversize_o(err_oversize_o)
`ifdef PACKET_SLOT_BUFFER_STATS_EN
    , .stat_commit_o(stat_commit_o), .stat_abort_o(stat_abort_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        wv;
    logic [10:0] waddr;
    logic [63:0] wdata;
    logic [2:0]  op;
    logic        wsv;
    logic [15:0] wsize;
    logic        commit;
    logic        abort;
    logic        rv;
    logic [10:0] raddr;
    logic        deq;
    logic [2:0]  e_cnt;
    logic        e_rsv;
    logic        e_wrdy;
    logic [15:0] e_size;
    logic        e_dv;
    logic [63:0] e_data;
    logic        e_em;
    logic        e_eo;
  } vec_t;

  localparam logic [63:0] D0   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] PA5  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] P5A  = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] W3   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WBE  = 64'h0000_0000_BEEF_0000;
  localparam logic [63:0] W3X  = 64'h0123_4567_BEEF_CDEF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CAFE = 64'hCAFE_F00D_1234_5678;

  int n_chk = 0;
  int n_fail = 0;

  vec_t q[$];
  vec_t t;
  int ecnt;
  logic [15:0] esz;
  logic eem, eeo;

  task automatic chk(input string nm, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  // Snapshot the running expected state into the vector being built.
  task automatic push();
    t.e_cnt  = 3'(ecnt);
    t.e_rsv  = (ecnt != 0);
    t.e_wrdy = (ecnt != 4);
    t.e_size = esz;
    t.e_em   = eem;
    t.e_eo   = eeo;
    q.push_back(t);
    t = '0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [63:0] d, input logic [2:0] op);
    t.wv = 1'b1; t.waddr = a; t.wdata = d; t.op = op;
  endtask

  task automatic idle();
    write_v_i = 0; write_addr_i = '0; write_data_i = '0; write_op_size_i = '0;
    write_size_v_i = 0; write_size_i = '0; write_slot_v_i = 0;
    write_slot_abort_i = 0; read_v_i = 0; read_addr_i = '0;
    read_slot_ready_and_i = 0;
  endtask

  task automatic drive(input vec_t v);
    write_v_i = v.wv; write_addr_i = v.waddr; write_data_i = v.wdata;
    write_op_size_i = v.op; write_size_v_i = v.wsv; write_size_i = v.wsize;
    write_slot_v_i = v.commit; write_slot_abort_i = v.abort;
    read_v_i = v.rv; read_addr_i = v.raddr; read_slot_ready_and_i = v.deq;
  endtask

  task automatic check_vec(input int i, input vec_t e);
    chk("count", i, 64'(slot_count_o), 64'(e.e_cnt));
    chk("read_slot_v", i, 64'(read_slot_v_o), 64'(e.e_rsv));
    chk("write_ready", i, 64'(write_slot_ready_and_o), 64'(e.e_wrdy));
    if (e.e_rsv) chk("read_size", i, 64'(read_size_r_o), 64'(e.e_size));
    chk("read_data_v", i, 64'(read_data_v_o), 64'(e.e_dv));
    if (e.e_dv) chk("read_data", i, read_data_o, e.e_data);
    chk("err_misalign", i, 64'(err_misalign_o), 64'(e.e_em));
    chk("err_oversize", i, 64'(err_oversize_o), 64'(e.e_eo));
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  initial begin
    // ---------------- vector table ----------------
    t = '0; ecnt = 0; esz = '0; eem = 0; eeo = 0;
    push();                                                 // idle after reset
    wr(11'd0, D0, 3'd3); push();                            // slot0 word0
    wr(11'd8, D1, 3'd3); push();                            // slot0 word1
    t.wsv = 1; t.wsize = 16; push();
    t.commit = 1; ecnt = 1; esz = 16; push();               // slot0 committed
    t.rv = 1; t.raddr = 11'd8; t.e_dv = 1; t.e_data = D1; push();
    push();                                                 // valid strobe drops
    t.wsv = 1; t.wsize = 32; push();
    t.commit = 1; ecnt = 2; push();
    t.wsv = 1; t.wsize = 48; push();
    t.commit = 1; ecnt = 3; push();
    t.wsv = 1; t.wsize = 3000; push();
    t.commit = 1; ecnt = 4; eeo = 1; push();                // full, size clamped
    t.commit = 1; push();                                   // commit while full ignored
    t.commit = 1; t.deq = 1; ecnt = 3; esz = 32; push();    // deq only
    t.deq = 1; ecnt = 2; esz = 48; push();
    t.deq = 1; ecnt = 1; esz = 2048; push();
    t.deq = 1; ecnt = 0; push();                            // rptr wraps to 0
    t.wsv = 1; t.wsize = 60; push();                        // slot0 again
    t.abort = 1; push();
    t.wsv = 1; t.wsize = 60; t.abort = 1; push();           // abort wins over size
    t.commit = 1; ecnt = 1; esz = 0; push();                // size was cleared
    t.deq = 1; ecnt = 0; push();
    wr(11'd0, PA5, 3'd3); t.wsv = 1; t.wsize = 64; push();  // slot1
    t.commit = 1; ecnt = 1; esz = 64; push();
    t.commit = 1; t.abort = 1; push();                      // abort wins, no commit
    wr(11'd0, P5A, 3'd3); t.wsv = 1; t.wsize = 8; push();   // slot2
    t.commit = 1; ecnt = 2; push();
    t.rv = 1; t.deq = 1; ecnt = 1; esz = 8; t.e_dv = 1; t.e_data = PA5; push();
    push();
    t.rv = 1; t.e_dv = 1; t.e_data = P5A; push();           // head is slot2
    push();
    wr(11'd0, W3, 3'd3); push();                            // slot3
    wr(11'd2, WBE, 3'd1); push();                           // 2-byte masked write
    wr(11'd1, ONES, 3'd1); eem = 1; push();                 // misaligned, dropped
    wr(11'd0, ONES, 3'd4); push();                          // 16 B op, dropped
    t.wsv = 1; t.wsize = 8; push();
    t.commit = 1; ecnt = 2; push();
    t.deq = 1; ecnt = 1; esz = 8; push();
    t.rv = 1; t.e_dv = 1; t.e_data = W3X; push();
    push();

    // ---------------- reset and run ----------------
    idle();
    reset_i = 1;
    step(); step();
    @(negedge clk_i); reset_i = 0;
    #1;
    chk("rst_count", 0, 64'(slot_count_o), 64'd0);
    chk("rst_read_slot_v", 0, 64'(read_slot_v_o), 64'd0);
    chk("rst_write_ready", 0, 64'(write_slot_ready_and_o), 64'd1);
    chk("rst_size", 0, 64'(read_size_r_o), 64'd0);
    chk("rst_read_data_v", 0, 64'(read_data_v_o), 64'd0);

    foreach (q[i]) begin
      @(negedge clk_i); drive(q[i]);
      step();
      check_vec(i, q[i]);
    end
    @(negedge clk_i); idle();

`ifdef PACKET_SLOT_BUFFER_STATS_EN
    chk("stat_commit", 0, 64'(stat_commit_o), 64'd8);
    chk("stat_abort", 0, 64'(stat_abort_o), 64'd3);
`endif

    // ---------------- reset with a packet resident ----------------
    reset_i = 1;
    step();
    chk("mid_rst_count", 0, 64'(slot_count_o), 64'd0);
    chk("mid_rst_read_slot_v", 0, 64'(read_slot_v_o), 64'd0);
    chk("mid_rst_write_ready", 0, 64'(write_slot_ready_and_o), 64'd1);
    chk("mid_rst_size", 0, 64'(read_size_r_o), 64'd0);
    chk("mid_rst_err_mis", 0, 64'(err_misalign_o), 64'd0);
    chk("mid_rst_err_over", 0, 64'(err_oversize_o), 64'd0);
`ifdef PACKET_SLOT_BUFFER_STATS_EN
    chk("mid_rst_stat_commit", 0, 64'(stat_commit_o), 64'd0);
    chk("mid_rst_stat_abort", 0, 64'(stat_abort_o), 64'd0);
`endif
    @(negedge clk_i); reset_i = 0;
    read_v_i = 1; read_addr_i = 11'd0;                      // read while empty
    step();
    chk("empty_read_dv", 0, 64'(read_data_v_o), 64'd0);
    chk("empty_read_err", 0, 64'(err_misalign_o), 64'd0);

    // ---------------- misaligned read ----------------
    @(negedge clk_i); idle();
    write_v_i = 1; write_addr_i = 11'd0; write_data_i = CAFE; write_op_size_i = 3'd3;
    write_size_v_i = 1; write_size_i = 16'd8;
    step();
    @(negedge clk_i); idle(); write_slot_v_i = 1;
    step();
    chk("seq_count", 0, 64'(slot_count_o), 64'd1);
    chk("seq_size", 0, 64'(read_size_r_o), 64'd8);
    @(negedge clk_i); idle(); read_v_i = 1; read_addr_i = 11'd3;
    step();
    chk("misread_dv", 0, 64'(read_data_v_o), 64'd1);
    chk("misread_data", 0, read_data_o, CAFE);
    chk("misread_err", 0, 64'(err_misalign_o), 64'd1);
    @(negedge clk_i); idle();
    step();
    chk("misread_dv_drop", 0, 64'(read_data_v_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
